// File: rtl/shape_prep_engine.sv
// Per-shape rotation prep: recomputes dirty shapes through a shared trig unit and
// double-buffers sin/cos/initial position so live outputs only change at a frame commit.
module shape_prep_engine #(
  parameter int NSHP  = 16,
  parameter int INTW  = 16,
  parameter int FRACW = 16,
  parameter int FLTW  = INTW + FRACW,
  parameter int IDW   = $clog2(NSHP)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mark_en,
  input  logic [IDW-1:0]       mark_id,
  input  logic                 mark_all,
  output logic [IDW-1:0]       rd_id,
  input  logic [INTW-1:0]      rd_x,
  input  logic [INTW-1:0]      rd_y,
  input  logic [INTW-1:0]      rd_angle,
  output logic                 trig_req,
  output logic [INTW-1:0]      trig_angle,
  input  logic                 trig_ack,
  input  logic [FLTW-1:0]      trig_sin,
  input  logic [FLTW-1:0]      trig_cos,
  input  logic                 newframe,
  output logic [NSHP*FLTW-1:0] o_sin,
  output logic [NSHP*FLTW-1:0] o_cos,
  output logic [NSHP*FLTW-1:0] o_ix,
  output logic [NSHP*FLTW-1:0] o_iy,
  output logic                 busy,
  output logic                 committed
);

  typedef enum logic [2:0] {IDLE, FETCH, REQ, MUL, STORE} state_t;

  localparam logic [FLTW-1:0] ONE_FX = FLTW'(1) << FRACW;

  state_t                   state_reg, state_next;
  logic [IDW-1:0]           cur_reg, cur_next;
  logic [NSHP-1:0]          dirty_reg, dirty_next;
  logic                     commit_pending_reg;
  logic                     committed_reg;
  logic                     commit_now;
  logic [INTW-1:0]          x0_reg, y0_reg, angle_reg;
  logic [FLTW-1:0]          sin_reg, cos_reg;
  logic signed [2*FLTW-1:0] p_xc_reg, p_ys_reg, p_xs_reg, p_yc_reg;
  logic signed [2*FLTW-1:0] x0_w, y0_w, sin_w, cos_w;

  logic [FLTW-1:0] sh_sin_reg [NSHP];
  logic [FLTW-1:0] sh_cos_reg [NSHP];
  logic [FLTW-1:0] sh_ix_reg  [NSHP];
  logic [FLTW-1:0] sh_iy_reg  [NSHP];
  logic [FLTW-1:0] lv_sin_reg [NSHP];
  logic [FLTW-1:0] lv_cos_reg [NSHP];
  logic [FLTW-1:0] lv_ix_reg  [NSHP];
  logic [FLTW-1:0] lv_iy_reg  [NSHP];

  function automatic logic [IDW-1:0] lowest(input logic [NSHP-1:0] v);
    lowest = '0;
    for (int i = NSHP - 1; i >= 0; i--) begin
      if (v[i]) lowest = IDW'(i);
    end
  endfunction

  // Positions are unsigned, so they are zero-extended before the signed multiply.
  assign x0_w  = {{(2*FLTW-INTW-FRACW){1'b0}}, x0_reg, {FRACW{1'b0}}};
  assign y0_w  = {{(2*FLTW-INTW-FRACW){1'b0}}, y0_reg, {FRACW{1'b0}}};
  assign sin_w = {{FLTW{sin_reg[FLTW-1]}}, sin_reg};
  assign cos_w = {{FLTW{cos_reg[FLTW-1]}}, cos_reg};

  assign commit_now = newframe && (state_reg == IDLE) && commit_pending_reg && (dirty_reg == '0);

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    dirty_next = dirty_reg;
    if (state_reg == STORE) dirty_next[cur_reg] = 1'b0;
    // Marks are applied after the clear so a same-cycle mark keeps the shape dirty.
    if (mark_all) dirty_next = '1;
    for (int i = 0; i < NSHP; i++) begin
      if (mark_en && (mark_id == IDW'(i))) dirty_next[i] = 1'b1;
    end
    case (state_reg)
      IDLE: begin
        if (|dirty_reg) begin
          cur_next   = lowest(dirty_reg);
          state_next = FETCH;
        end
      end
      FETCH: state_next = REQ;
      REQ:   if (trig_ack) state_next = MUL;
      MUL:   state_next = STORE;
      STORE: begin
        if (|dirty_next) begin
          cur_next   = lowest(dirty_next);
          state_next = FETCH;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      cur_reg            <= '0;
      dirty_reg          <= '1;
      commit_pending_reg <= 1'b0;
      committed_reg      <= 1'b0;
      x0_reg             <= '0;
      y0_reg             <= '0;
      angle_reg          <= '0;
      sin_reg            <= '0;
      cos_reg            <= '0;
      p_xc_reg           <= '0;
      p_ys_reg           <= '0;
      p_xs_reg           <= '0;
      p_yc_reg           <= '0;
      for (int k = 0; k < NSHP; k++) begin
        sh_sin_reg[k] <= '0;
        sh_cos_reg[k] <= ONE_FX;
        sh_ix_reg[k]  <= '0;
        sh_iy_reg[k]  <= '0;
        lv_sin_reg[k] <= '0;
        lv_cos_reg[k] <= ONE_FX;
        lv_ix_reg[k]  <= '0;
        lv_iy_reg[k]  <= '0;
      end
    end else begin
      state_reg     <= state_next;
      cur_reg       <= cur_next;
      dirty_reg     <= dirty_next;
      committed_reg <= commit_now;
      if (state_reg == FETCH) begin
        x0_reg    <= rd_x;
        y0_reg    <= rd_y;
        angle_reg <= rd_angle;
      end
      if ((state_reg == REQ) && trig_ack) begin
        sin_reg <= trig_sin;
        cos_reg <= trig_cos;
      end
      if (state_reg == MUL) begin
        p_xc_reg <= x0_w * cos_w;
        p_ys_reg <= y0_w * sin_w;
        p_xs_reg <= x0_w * sin_w;
        p_yc_reg <= y0_w * cos_w;
      end
      if (state_reg == STORE) begin
        sh_sin_reg[cur_reg] <= sin_reg;
        sh_cos_reg[cur_reg] <= cos_reg;
        sh_ix_reg[cur_reg]  <= FLTW'((p_ys_reg - p_xc_reg) >>> FRACW);
        sh_iy_reg[cur_reg]  <= FLTW'((-p_xs_reg - p_yc_reg) >>> FRACW);
        commit_pending_reg  <= 1'b1;
      end
      if (commit_now) begin
        commit_pending_reg <= 1'b0;
        for (int k = 0; k < NSHP; k++) begin
          lv_sin_reg[k] <= sh_sin_reg[k];
          lv_cos_reg[k] <= sh_cos_reg[k];
          lv_ix_reg[k]  <= sh_ix_reg[k];
          lv_iy_reg[k]  <= sh_iy_reg[k];
        end
      end
    end
  end

  assign rd_id      = cur_reg;
  assign trig_req   = (state_reg == REQ);
  assign trig_angle = angle_reg;
  assign busy       = (state_reg != IDLE);
  assign committed  = committed_reg;

  for (genvar gi = 0; gi < NSHP; gi++) begin : g_pack
    assign o_sin[gi*FLTW +: FLTW] = lv_sin_reg[gi];
    assign o_cos[gi*FLTW +: FLTW] = lv_cos_reg[gi];
    assign o_ix[gi*FLTW +: FLTW]  = lv_ix_reg[gi];
    assign o_iy[gi*FLTW +: FLTW]  = lv_iy_reg[gi];
  end

endmodule

// File: tb/tb_shape_prep_engine.sv
// Directed + randomized bench for shape_prep_engine with a behavioural trig unit,
// parameter memory and a shadow/live reference model.
module tb_shape_prep_engine;
  localparam int NSHP = 16;
  localparam int INTW = 16;
  localparam int FLTW = 32;
  localparam int IDW  = 4;

  logic                 clk = 1'b0;
  logic                 rst, mark_en, mark_all, newframe;
  logic [IDW-1:0]       mark_id, rd_id;
  logic [INTW-1:0]      rd_x, rd_y, rd_angle, trig_angle;
  logic                 trig_req, trig_ack, busy, committed;
  logic [FLTW-1:0]      trig_sin, trig_cos;
  logic [NSHP*FLTW-1:0] o_sin, o_cos, o_ix, o_iy;

  shape_prep_engine dut (
    .clk(clk), .rst(rst), .mark_en(mark_en), .mark_id(mark_id), .mark_all(mark_all),
    .rd_id(rd_id), .rd_x(rd_x), .rd_y(rd_y), .rd_angle(rd_angle),
    .trig_req(trig_req), .trig_angle(trig_angle), .trig_ack(trig_ack),
    .trig_sin(trig_sin), .trig_cos(trig_cos), .newframe(newframe),
    .o_sin(o_sin), .o_cos(o_cos), .o_ix(o_ix), .o_iy(o_iy),
    .busy(busy), .committed(committed)
  );

  always #5 clk = ~clk;

  // Shape parameter memory and trig lookup (index = angle + 180).
  logic [INTW-1:0] mem_x [NSHP];
  logic [INTW-1:0] mem_y [NSHP];
  logic [INTW-1:0] mem_a [NSHP];
  logic [FLTW-1:0] lut_s [360];
  logic [FLTW-1:0] lut_c [360];
  assign rd_x     = mem_x[rd_id];
  assign rd_y     = mem_y[rd_id];
  assign rd_angle = mem_a[rd_id];

  logic [FLTW-1:0] ex_sh_sin [NSHP];
  logic [FLTW-1:0] ex_sh_cos [NSHP];
  logic [FLTW-1:0] ex_sh_ix  [NSHP];
  logic [FLTW-1:0] ex_sh_iy  [NSHP];
  logic [FLTW-1:0] ex_lv_sin [NSHP];
  logic [FLTW-1:0] ex_lv_cos [NSHP];
  logic [FLTW-1:0] ex_lv_ix  [NSHP];
  logic [FLTW-1:0] ex_lv_iy  [NSHP];

  int n_cmp = 0;
  int n_bad = 0;
  int trig_delay = 0;
  int req_len, last_req_len, n_acks;
  logic angle_ok, last_angle_ok;
  logic [INTW-1:0] req_angle;

  // Trig unit: acks after trig_delay extra cycles of a held request.
  initial begin
    int a;
    trig_ack = 0; trig_sin = '0; trig_cos = '0;
    req_len = 0; last_req_len = 0; n_acks = 0; angle_ok = 1; last_angle_ok = 1; req_angle = '0;
    forever begin
      @(negedge clk);
      trig_ack = 0;
      if (trig_req) begin
        if (req_len == 0) begin
          req_angle = trig_angle;
          angle_ok  = 1;
        end else if (trig_angle !== req_angle) begin
          angle_ok = 0;
        end
        req_len++;
        if (req_len > trig_delay) begin
          a = int'($signed(trig_angle)) + 180;
          if (a < 0 || a > 359) a = 0;
          trig_ack = 1;
          trig_sin = lut_s[a];
          trig_cos = lut_c[a];
          last_req_len  = req_len;
          last_angle_ok = angle_ok;
          req_len = 0;
          n_acks++;
        end
      end else begin
        req_len = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [NSHP*FLTW-1:0] obs, input logic [NSHP*FLTW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NSHP*FLTW-1:0] pack(input logic [FLTW-1:0] v [NSHP]);
    logic [NSHP*FLTW-1:0] p;
    for (int k = 0; k < NSHP; k++) p[k*FLTW +: FLTW] = v[k];
    return p;
  endfunction

  // Reference: ix = (-x*cos + y*sin)/2^16, iy = (-x*sin - y*cos)/2^16, floor division, 32-bit wrap.
  task automatic model(input int k);
    int a;
    longint x, y, s, c, t;
    a = int'($signed(mem_a[k])) + 180;
    x = longint'(mem_x[k]) * 65536;
    y = longint'(mem_y[k]) * 65536;
    s = longint'($signed(lut_s[a]));
    c = longint'($signed(lut_c[a]));
    ex_sh_sin[k] = lut_s[a];
    ex_sh_cos[k] = lut_c[a];
    t = y * s - x * c;
    ex_sh_ix[k] = 32'(t >>> 16);
    t = -x * s - y * c;
    ex_sh_iy[k] = 32'(t >>> 16);
  endtask

  task automatic reset_model();
    for (int k = 0; k < NSHP; k++) begin
      ex_sh_sin[k] = '0; ex_sh_cos[k] = 32'h0001_0000; ex_sh_ix[k] = '0; ex_sh_iy[k] = '0;
      ex_lv_sin[k] = '0; ex_lv_cos[k] = 32'h0001_0000; ex_lv_ix[k] = '0; ex_lv_iy[k] = '0;
    end
  endtask

  task automatic rand_shape(input int k);
    mem_x[k] = 16'($urandom);
    mem_y[k] = 16'($urandom);
    mem_a[k] = 16'(int'($urandom_range(0, 359)) - 180);
  endtask

  task automatic check_live(input string tag);
    chk({tag, "_sin"}, o_sin, pack(ex_lv_sin));
    chk({tag, "_cos"}, o_cos, pack(ex_lv_cos));
    chk({tag, "_ix"},  o_ix,  pack(ex_lv_ix));
    chk({tag, "_iy"},  o_iy,  pack(ex_lv_iy));
  endtask

  task automatic mark_one(input int id);
    @(negedge clk);
    mark_en = 1; mark_id = IDW'(id);
    @(negedge clk);
    mark_en = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, NSHP*FLTW'(busy), '0);
  endtask

  // Pulse newframe; a commit makes the model's live copy equal its shadow copy.
  task automatic frame(input logic exp_commit, input string tag);
    @(negedge clk);
    newframe = 1;
    @(negedge clk);
    newframe = 0;
    chk({tag, "_committed"}, NSHP*FLTW'(committed), NSHP*FLTW'(exp_commit));
    if (exp_commit) begin
      ex_lv_sin = ex_sh_sin; ex_lv_cos = ex_sh_cos; ex_lv_ix = ex_sh_ix; ex_lv_iy = ex_sh_iy;
    end
    @(negedge clk);
    chk({tag, "_pulse_end"}, NSHP*FLTW'(committed), '0);
    check_live(tag);
    $display("frame %s: committed expected %0d", tag, exp_commit);
  endtask

  initial begin
    int k, acks0, n;
    rst = 1; mark_en = 0; mark_id = '0; mark_all = 0; newframe = 0;
    for (int i = 0; i < NSHP; i++) begin
      mem_x[i] = '0; mem_y[i] = '0; mem_a[i] = '0;
    end
    for (int i = 0; i < 360; i++) begin
      lut_s[i] = '0; lut_c[i] = 32'h0001_0000;
    end
    reset_model();
    trig_delay = 4;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", NSHP*FLTW'(busy), '0);
    chk("rst_trig_req", NSHP*FLTW'(trig_req), '0);
    chk("rst_committed", NSHP*FLTW'(committed), '0);
    chk("rst_rd_id", NSHP*FLTW'(rd_id), '0);
    check_live("rst_live");

    // All shapes dirty after reset; zero parameters, identity trig
    rst = 0;
    for (int i = 0; i < NSHP; i++) model(i);
    wait_idle("boot");
    frame(1, "boot");

    // Two marks; a newframe while shape 8 is still in flight must not commit
    for (int i = 0; i < NSHP; i++) rand_shape(i);
    for (int i = 0; i < 360; i++) begin
      lut_s[i] = $urandom; lut_c[i] = $urandom;
    end
    lut_s[270] = 32'h0001_0000; lut_c[270] = '0;
    mem_x[3] = 16'd100; mem_y[3] = 16'd50; mem_a[3] = 16'd90;
    mark_one(3); model(3);
    mark_one(8); model(8);
    repeat (10) @(negedge clk);
    chk("busy_mid", NSHP*FLTW'(busy), NSHP*FLTW'(1'b1));
    frame(0, "nf_busy");
    wait_idle("s3");
    frame(1, "s3");
    chk("ix3", NSHP*FLTW'(o_ix[3*FLTW +: FLTW]), NSHP*FLTW'(32'h0032_0000));
    chk("iy3", NSHP*FLTW'(o_iy[3*FLTW +: FLTW]), NSHP*FLTW'(32'hFF9C_0000));

    // Randomized marking rounds, one using mark_all
    for (int r = 0; r < 4; r++) begin
      trig_delay = int'($urandom_range(0, 5));
      n = int'($urandom_range(1, 4));
      for (int j = 0; j < n; j++) begin
        k = int'($urandom_range(0, NSHP - 1));
        rand_shape(k);
        mark_one(k);
        model(k);
      end
      if (r == 2) begin
        @(negedge clk);
        mark_all = 1;
        @(negedge clk);
        mark_all = 0;
        for (int i = 0; i < NSHP; i++) model(i);
      end
      wait_idle("rnd");
      frame(1, "rnd");
    end

    // Long trig wait: request held delay+1 cycles with a stable angle
    trig_delay = 20;
    rand_shape(5);
    mark_one(5); model(5);
    wait_idle("slow");
    chk("slow_req_len", NSHP*FLTW'(last_req_len), NSHP*FLTW'(21));
    chk("slow_angle_stable", NSHP*FLTW'(last_angle_ok), NSHP*FLTW'(1'b1));
    frame(1, "slow");

    // Mark during STORE of the same shape: it must be fetched again
    trig_delay = 2;
    rand_shape(7);
    acks0 = n_acks;
    mark_one(7);
    n = 0;
    @(posedge clk);
    while (!trig_ack && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("store_ack_seen", NSHP*FLTW'(trig_ack), NSHP*FLTW'(1'b1));
    @(negedge clk);
    @(negedge clk);
    rand_shape(7);
    mark_en = 1; mark_id = 4'd7;
    @(negedge clk);
    mark_en = 0;
    model(7);
    wait_idle("store_mark");
    chk("store_mark_acks", NSHP*FLTW'(n_acks - acks0), NSHP*FLTW'(2));
    frame(1, "store_mark");

    // Reset while waiting in REQ
    trig_delay = 20;
    rand_shape(2);
    mark_one(2);
    n = 0;
    while (!trig_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_req", NSHP*FLTW'(trig_req), NSHP*FLTW'(1'b1));
    rst = 1;
    @(negedge clk);
    chk("rst_req_drop", NSHP*FLTW'(trig_req), '0);
    chk("rst_busy2", NSHP*FLTW'(busy), '0);
    reset_model();
    check_live("rst_live2");
    rst = 0;
    trig_delay = 1;
    for (int i = 0; i < NSHP; i++) model(i);
    wait_idle("after_rst");
    frame(1, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shape_prep_engine.md
Name: shape_prep_engine

Overview:
- Parametrised successor to the fixed per-shape sin/cos/initial-rotation loop in the control core.
- Recomputes only shapes marked dirty and fetches parameters through a read port.
- Talks to a shared trig unit over a variable-latency req/ack handshake.
- Double-buffers results so renderers see new values only at a frame boundary, never torn mid-frame.

Parameters:
- NSHP, 16, number of shapes (≥2).
- INTW, 16, integer width of x/y/angle.
- FRACW, 16, fraction bits; FLTW = INTW+FRACW.
- IDW, $clog2(NSHP), shape index width.

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  synchronous, active-high reset
- mark_en  in  1  mark shape mark_id dirty
- mark_id  in  IDW  shape to mark
- mark_all  in  1  mark every shape dirty
- rd_id  out  IDW  parameter read address
- rd_x, rd_y  in  INTW  shape position, unsigned, valid combinationally for rd_id
- rd_angle  in  INTW  signed degrees, −180..179
- trig_req  out  1  trig request
- trig_angle  out  INTW  angle for request
- trig_ack  in  1  one-cycle ack; trig_sin/trig_cos valid that cycle
- trig_sin, trig_cos  in  FLTW  signed fixed-point
- newframe  in  1  one-cycle frame-start pulse
- o_sin, o_cos, o_ix, o_iy  out  NSHP*FLTW  live values; shape k at [k*FLTW +: FLTW]
- busy  out  1  state ≠ IDLE
- committed  out  1  one-cycle pulse when shadow is copied to live

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, all dirty bits=1, commit_pending=0, trig_req=0, committed=0, rd_id=0.
  - Live and shadow: sin=0, cos=1<<FRACW, ix=iy=0.
  - Reset mid-operation aborts the computation with no shadow write.
- States:
  - IDLE: if any dirty bit is set, cur ← lowest-index dirty shape, go FETCH.
  - FETCH: rd_id=cur; latch x0, y0, angle; go REQ.
  - REQ: trig_req=1 and trig_angle held stable until the cycle trig_ack=1; latch sin/cos; go MUL. No timeout.
  - MUL: register four products, each FLTW×FLTW→2·FLTW signed, with x0/y0 zero-extended to fixed point (x0<<FRACW); go STORE.
  - STORE:
    - ix = (−x0·cos + y0·sin) >>> FRACW and iy = (−x0·sin − y0·cos) >>> FRACW, truncated to FLTW (arithmetic shift, wrap on overflow).
    - Write shadow[cur]; clear dirty[cur]; set commit_pending.
    - Go FETCH with the next dirty index if any remain, else IDLE.
- Latency: FETCH→STORE = 3 + trig wait cycles per shape.
- Dirty marking:
  - A mark in the same cycle as the STORE clear for that id wins; the bit stays set and the shape is recomputed.
  - mark_all ORs with mark_en.
  - Marks are accepted in every state.
- Commit:
  - On newframe with state=IDLE, commit_pending=1 and no dirty bits set: copy all shadow to live at that edge, clear commit_pending, pulse committed next cycle.
  - Otherwise the commit is deferred to a later newframe. Live outputs never change except at a commit or reset.
- Scan order is strictly lowest index first on every selection; there is no round-robin.

Test Plan:
- Reset, no marks, rd_* all 0, trig returns sin=0 cos=0x10000 after 4 cycles → 16 shapes computed; committed pulses on first newframe after busy falls; o_cos[k]=0x00010000, o_ix=o_iy=0.
- mark id 3, rd_x=100, rd_y=50, angle=90, trig sin=0x00010000 cos=0 → after commit o_ix[3]=0x00320000, o_iy[3]=0xFF9C0000; other shapes unchanged.
- newframe while busy → no copy, live stable; next newframe after idle → copy plus committed pulse.
- trig_ack delayed 20 cycles → trig_req held 21 cycles, trig_angle constant; result is correct.
- mark_en for cur in the STORE cycle → dirty stays set; shape recomputed once more before IDLE.
- Assert rst during REQ → trig_req low next cycle; all dirty bits set; live reset to cos=1.0, sin/ix/iy=0.
